// File: rtl/addsub_mb_arbiter_if.sv
// ----------------------------------------------------------------------------
// addsub_mb_arbiter_if
// Bundle of request/response signals for the two-requester add/subtract
// arbiter.
//   req0_* / req1_* : valid/ready request channels with 32-bit operands A and B
//                     and a mode bit (0 = add, 1 = subtract)
//   rsp_*           : valid/ready response channel with requester id,
//                     32-bit result and carry/borrow
// Modports:
//   master : requester/consumer side (drives requests and rsp_ready)
//   slave  : arbiter side (drives ready outputs and the response)
// ----------------------------------------------------------------------------
interface addsub_mb_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_mode;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_mode;

    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        output req1_valid, req1_a, req1_b, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry
    );
endinterface

// File: rtl/addsub_mb_arbiter.sv
// ----------------------------------------------------------------------------
// addsub_mb_arbiter
// Two requesters share a single 8-bit add/subtract slice. An accepted 32-bit
// operation is processed as four byte steps (byte 0 first) with the carry
// chained between steps, then held on the response channel until consumed.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : addsub_mb_arbiter_if.slave (request channels 0/1, response channel)
// Timing: accept edge -> 4 CALC edges -> RESP; rsp_valid rises 4 edges after
// the accept; one IDLE cycle after the response handshake (6 cycles minimum).
// ----------------------------------------------------------------------------
module addsub_mb_arbiter (
    input logic                      clk,
    input logic                      rst,
    addsub_mb_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;            // operand A, shifted right one byte per step
    logic [31:0] b_q, b_d;            // operand B, shifted right one byte per step
    logic [31:0] result_q, result_d;  // result bytes shifted in from the top
    logic        mode_q, mode_d;
    logic        id_q, id_d;
    logic        carry_q, carry_d;    // carry chained between byte steps
    logic        rsp_carry_q, rsp_carry_d;
    logic [1:0]  idx_q, idx_d;        // byte currently being processed
    logic        last_q, last_d;      // requester granted most recently

    logic        grant0, grant1;
    logic        accept0, accept1;
    logic        idle_open;
    logic [7:0]  b_byte;
    logic [8:0]  byte_sum;

    // ------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the one not granted
    // last wins. last_q resets to 1 so req0 takes the first tie.
    // ------------------------------------------------------------------------
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    // Ready is combinational in IDLE; gated by rst so it is low while reset
    // is held even though the state register already reads IDLE.
    assign idle_open      = (state_q == StIdle) && !rst;
    assign bus.req0_ready = idle_open && grant0;
    assign bus.req1_ready = idle_open && grant1;
    assign accept0        = bus.req0_ready;
    assign accept1        = bus.req1_ready;

    // ------------------------------------------------------------------------
    // Shared byte slice: subtract is A + ~B + 1, the +1 coming from the
    // initial carry loaded at accept.
    // ------------------------------------------------------------------------
    assign b_byte   = mode_q ? ~b_q[7:0] : b_q[7:0];
    assign byte_sum = {1'b0, a_q[7:0]} + {1'b0, b_byte} + {8'd0, carry_q};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        mode_d      = mode_q;
        id_d        = id_q;
        carry_d     = carry_q;
        rsp_carry_d = rsp_carry_q;
        idx_d       = idx_q;
        last_d      = last_q;

        unique case (state_q)
            StIdle: begin
                if (accept0 || accept1) begin
                    a_d     = accept1 ? bus.req1_a    : bus.req0_a;
                    b_d     = accept1 ? bus.req1_b    : bus.req0_b;
                    mode_d  = accept1 ? bus.req1_mode : bus.req0_mode;
                    id_d    = accept1;
                    last_d  = accept1;
                    carry_d = accept1 ? bus.req1_mode : bus.req0_mode;
                    idx_d   = 2'd0;
                    state_d = StCalc;
                end
            end

            StCalc: begin
                a_d      = {8'd0, a_q[31:8]};
                b_d      = {8'd0, b_q[31:8]};
                result_d = {byte_sum[7:0], result_q[31:8]};
                carry_d  = byte_sum[8];
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // Subtract reports a borrow, i.e. the inverted carry-out.
                    rsp_carry_d = mode_q ? ~byte_sum[8] : byte_sum[8];
                    state_d     = StResp;
                end
            end

            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            result_q    <= 32'd0;
            mode_q      <= 1'b0;
            id_q        <= 1'b0;
            carry_q     <= 1'b0;
            rsp_carry_q <= 1'b0;
            idx_q       <= 2'd0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            carry_q     <= carry_d;
            rsp_carry_q <= rsp_carry_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response outputs: registers only change in IDLE/CALC, so they are
    // stable for the whole RESP period.
    // ------------------------------------------------------------------------
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_addsub_mb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_addsub_mb_arbiter
// Directed bench for addsub_mb_arbiter: reset values, add/subtract vectors
// with hand-computed results, response latency, round-robin order, response
// back-pressure and reset abort during CALC.
// ----------------------------------------------------------------------------
module tb_addsub_mb_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    addsub_mb_arbiter_if bus ();

    addsub_mb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic m);
        if (r == 0) begin
            bus.req0_valid = v;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_mode  = m;
        end else begin
            bus.req1_valid = v;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_mode  = m;
        end
    endtask

    // Waits (bounded) for requester r to see ready, lets the accept edge pass,
    // then drops valid and scrambles its operands. Returns at accept edge + 1.
    task automatic wait_accept(input string tag, input int r);
        int   n;
        logic rdy;
        n   = 0;
        #1;
        rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
        while (!rdy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            rdy = (r == 0) ? bus.req0_ready : bus.req1_ready;
        end
        chk({tag, " accepted"}, 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        set_req(r, 1'b0, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic issue(input string tag, input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic m);
        @(negedge clk);
        set_req(r, 1'b1, a, b, m);
        wait_accept(tag, r);
    endtask

    // Called at accept edge + 1: checks latency and payload, then handshakes.
    task automatic expect_rsp(input string tag, input logic id, input logic [31:0] res,
                              input logic c);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd4);
        chk({tag, " id"}, 64'(bus.rsp_id), 64'(id));
        chk({tag, " result"}, 64'(bus.rsp_result), 64'(res));
        chk({tag, " carry"}, 64'(bus.rsp_carry), 64'(c));
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk({tag, " valid low after handshake"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        int n;
        checks        = 0;
        fails         = 0;
        bus.rsp_ready = 1'b0;

        // Reset values, with both requesters already asserting valid.
        rst = 1'b1;
        set_req(0, 1'b1, 32'h1, 32'h2, 1'b0);
        set_req(1, 1'b1, 32'h3, 32'h4, 1'b1);
        #3;
        chk("reset outputs", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_result}),
            64'd0);
        chk("reset readys", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed add/subtract vectors.
        issue("add ff+1", 0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        expect_rsp("add ff+1", 1'b0, 32'h0000_0100, 1'b0);
        issue("add wrap", 1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        expect_rsp("add wrap", 1'b1, 32'h0000_0000, 1'b1);
        issue("sub 5-7", 0, 32'd5, 32'd7, 1'b1);
        expect_rsp("sub 5-7", 1'b0, 32'hFFFF_FFFE, 1'b1);
        issue("sub 7-5", 1, 32'd7, 32'd5, 1'b1);
        expect_rsp("sub 7-5", 1'b1, 32'h0000_0002, 1'b0);
        issue("sub min-1", 0, 32'h8000_0000, 32'h0000_0001, 1'b1);
        expect_rsp("sub min-1", 1'b0, 32'h7FFF_FFFF, 1'b0);
        issue("add chain", 1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        expect_rsp("add chain", 1'b1, 32'hACF1_3568, 1'b0);
        issue("add top carry", 0, 32'hF000_0000, 32'h2000_0000, 1'b0);
        expect_rsp("add top carry", 1'b0, 32'h1000_0000, 1'b1);

        // Round robin with both requesters valid continuously from reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_req(0, 1'b1, 32'd100, 32'd1, 1'b0);  // 0x65
        set_req(1, 1'b1, 32'd200, 32'd3, 1'b1);  // 0xC5
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.rsp_valid && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("rr valid", 64'(bus.rsp_valid), 64'd1);
            if (k[0]) chk("rr rsp1", 64'({bus.rsp_id, bus.rsp_carry, bus.rsp_result}),
                          64'({1'b1, 1'b0, 32'h0000_00C5}));
            else      chk("rr rsp0", 64'({bus.rsp_id, bus.rsp_carry, bus.rsp_result}),
                          64'({1'b0, 1'b0, 32'h0000_0065}));
            if (k == 3) begin
                set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
                set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b0;
        chk("rr idle after", 64'(bus.rsp_valid), 64'd0);

        // Back-pressure: response held for 10 cycles with both requesters valid.
        issue("stall", 1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall latency", 64'(n), 64'd4);
        set_req(0, 1'b1, 32'h5, 32'h5, 1'b0);
        set_req(1, 1'b1, 32'h6, 32'h6, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("stall hold", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_result,
                                   bus.req0_ready, bus.req1_ready}),
                64'({1'b1, 1'b1, 1'b0, 32'hCD9C_ADDE, 1'b0, 1'b0}));
        end
        set_req(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_req(1, 1'b0, 32'h0, 32'h0, 1'b0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("stall release", 64'(bus.rsp_valid), 64'd0);

        // Reset in the second CALC cycle aborts the operation.
        issue("abort", 0, 32'h0102_0304, 32'h0101_0101, 1'b0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 32'h10, 32'h20, 1'b0);
        set_req(1, 1'b1, 32'h50, 32'h60, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort outputs", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_result,
                                  bus.req0_ready, bus.req1_ready}), 64'd0);
        @(posedge clk);
        #1;
        chk("abort held", 64'({bus.rsp_valid, bus.req0_ready, bus.req1_ready}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort tie grant", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
        wait_accept("post abort 0", 0);
        expect_rsp("post abort 0", 1'b0, 32'h0000_0030, 1'b0);
        wait_accept("post abort 1", 1);
        expect_rsp("post abort 1", 1'b1, 32'hFFFF_FFF0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
